// File: rtl/arbitro_mem_dados.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_mem_dados
// Description : Arbiter/sequencer for the 8-bit x 256 data memory. Shares the
//               memory's single read/write port between requester A (datapath)
//               and requester B (I/O / DMA), and runs a memory-clear sweep on
//               command. It is the only driver of the memory interface.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   FIXED_PRIORITY_EN  defined   -> A always wins ties, no round-robin pointer
//                      undefined -> round-robin between A and B (default)
// ----------------------------------------------------------------------------
// Ports:
//   clk                 clock, all state on rising edge
//   clr                 asynchronous active-low reset
//   req_a / req_b       level requests, held until the matching ack
//   we_a / we_b         1 = write, 0 = read, sampled at grant
//   addr_a / addr_b     access address
//   wdata_a / wdata_b   write data
//   ack_a / ack_b       one-cycle completion pulse (CAPTURE cycle)
//   rdata               read result, valid with ack, held until next read
//   clear_req           start a clear sweep (sampled only in IDLE)
//   clear_done          one-cycle pulse in the IDLE cycle after the sweep
//   busy                high whenever the sequencer is not IDLE
//   mem_read/mem_write  registered memory strobes, never both high
//   mem_endereco        registered memory address
//   mem_dado            registered memory write data
//   mem_saida           memory read data (valid while mem_read is high)
// ----------------------------------------------------------------------------
// Timing: request sampled at IDLE edge N -> ACCESS cycle (strobe high) ->
// CAPTURE cycle with ack and rdata. mem_saida is registered at the end of the
// ACCESS cycle so that rdata is already valid while ack is high.
// ============================================================================
module arbitro_mem_dados #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_req,
  output logic              clear_done,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_dado,
  input  logic [DATA_W-1:0] mem_saida
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_t            state;
  logic              sel_b;      // winner of the access in flight (1 = B)
  logic              op_we;      // frozen write-enable of the access in flight
  logic [ADDR_W-1:0] sweep_cnt;  // clear sweep address, wraps back to 0
  logic              grant_b;    // winner select evaluated in IDLE

`ifdef FIXED_PRIORITY_EN
  // B is served only when A is not asking.
  always_comb begin
    grant_b = !req_a;
  end
`else
  logic last_b;  // 1 when the most recent completed access belonged to B

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_b = req_b && (!req_a || !last_b);
  end
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= S_IDLE;
      sel_b        <= 1'b0;
      op_we        <= 1'b0;
      sweep_cnt    <= '0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      rdata        <= '0;
      clear_done   <= 1'b0;
      busy         <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_endereco <= '0;
      mem_dado     <= '0;
`ifdef FIXED_PRIORITY_EN
`else
      last_b       <= 1'b1;  // first tie after reset goes to A
`endif
    end else begin
      // Pulses default low and are raised only for one cycle below.
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            state        <= S_CLEAR;
            busy         <= 1'b1;
            mem_write    <= 1'b1;
            mem_dado     <= '0;
            mem_endereco <= sweep_cnt;
          end else if (req_a || req_b) begin
            // Winner's controls are captured here and stay frozen.
            state        <= S_ACCESS;
            busy         <= 1'b1;
            sel_b        <= grant_b;
            op_we        <= grant_b ? we_b : we_a;
            mem_write    <= grant_b ? we_b : we_a;
            mem_read     <= grant_b ? !we_b : !we_a;
            mem_endereco <= grant_b ? addr_b : addr_a;
            mem_dado     <= grant_b ? wdata_b : wdata_a;
          end
        end
        S_ACCESS: begin
          state     <= S_CAPTURE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (!op_we) begin
            rdata <= mem_saida;
          end
          ack_a <= !sel_b;
          ack_b <= sel_b;
`ifdef FIXED_PRIORITY_EN
`else
          last_b <= sel_b;
`endif
        end
        S_CAPTURE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_CLEAR: begin
          if (sweep_cnt == LAST_ADDR) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            mem_write  <= 1'b0;
            clear_done <= 1'b1;
            sweep_cnt  <= '0;
          end else begin
            sweep_cnt    <= sweep_cnt + 1'b1;
            mem_endereco <= sweep_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_mem_dados.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_mem_dados
// Description : Self-checking bench for arbitro_mem_dados. Contains a simple
//               memory model (write on clock, combinational read) and a
//               transaction-level reference of memory contents, read data and
//               arbitration order. Honours FIXED_PRIORITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_mem_dados;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 256;

  logic clk = 1'b0;
  logic clr, req_a, req_b, we_a, we_b, clear_req;
  logic [ADDR_W-1:0] addr_a, addr_b, mem_endereco;
  logic [DATA_W-1:0] wdata_a, wdata_b, rdata, mem_dado, mem_saida;
  logic ack_a, ack_b, clear_done, busy, mem_read, mem_write;

  int n_assert = 0;
  int n_fail   = 0;
  int cd_count = 0;

  logic [DATA_W-1:0] mem     [MEM_DEPTH];
  logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
  bit                ref_valid [MEM_DEPTH];
  bit                last_b_ref;   // requester served most recently (1 = B)
  logic [DATA_W-1:0] exp_rdata;

  always #5 clk = ~clk;

  arbitro_mem_dados #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk), .clr(clr),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata),
    .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_endereco(mem_endereco), .mem_dado(mem_dado), .mem_saida(mem_saida)
  );

  // Data memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_write) mem[mem_endereco] <= mem_dado;
  end
  assign mem_saida = mem[mem_endereco];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clear_done) cd_count++;
    if (mem_read || mem_write) chk("strobe_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: a lone requester wins; on a tie, the one not served
  // last wins (or always A with fixed priority).
  function automatic bit exp_winner_b(input bit ra, input bit rb);
    if (ra && !rb) return 1'b0;
    if (rb && !ra) return 1'b1;
`ifdef FIXED_PRIORITY_EN
    return 1'b0;
`else
    return last_b_ref ? 1'b0 : 1'b1;
`endif
  endfunction

  // One transaction from a single requester, starting in an IDLE cycle.
  task automatic single(input bit use_b, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (use_b) begin req_b = 1; we_b = we; addr_b = a; wdata_b = d; end
    else begin req_a = 1; we_a = we; addr_a = a; wdata_a = d; end
    tick();
    chk("acc_strobes", {mem_write, mem_read}, {we, !we});
    chk("acc_addr", mem_endereco, a);
    if (we) chk("acc_wdata", mem_dado, d);
    chk("acc_no_ack", {ack_a, ack_b}, 2'b00);
    // Granted values must stay frozen even if the requester changes them.
    if (use_b) begin we_b = !we; addr_b = ~a; wdata_b = ~d; end
    else begin we_a = !we; addr_a = ~a; wdata_a = ~d; end
    if (!we) exp_rdata = ref_mem[a];
    else begin ref_mem[a] = d; ref_valid[a] = 1'b1; end
    last_b_ref = use_b;
    tick();
    chk("ack_winner", {ack_a, ack_b}, {!use_b, use_b});
    chk("rdata", rdata, exp_rdata);
    chk("busy_capture", busy, 1);
    if (use_b) req_b = 0; else req_a = 0;
    tick();
    chk("idle_quiet", {busy, ack_a, ack_b, mem_read, mem_write}, 5'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit        ub, w, got, wb;
    logic [7:0] a, da, db;
    int        waited, cyc, prev, cd0;

    clr = 0; req_a = 0; req_b = 0; we_a = 0; we_b = 0; clear_req = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    last_b_ref = 1'b1; exp_rdata = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin ref_mem[i] = '0; ref_valid[i] = 1'b0; end

    // Reset held with a pending request: everything quiet.
    req_a = 1; we_a = 1; addr_a = 8'h10; wdata_a = 8'h5A;
    tick(); tick();
    chk("reset_outputs", {ack_a, ack_b, rdata, clear_done, busy, mem_read, mem_write,
                          mem_endereco, mem_dado}, 32'd0);
    clr = 1;
    // A writes 5A @ 10, then B reads it back.
    single(0, 1, 8'h10, 8'h5A);
    single(1, 0, 8'h10, 8'h00);

    // Random single-requester traffic in a small address window.
    for (int t = 0; t < 10; t++) begin
      ub = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(8'h40, 8'h47));
      if (!w && !ref_valid[a]) w = 1'b1;
      single(ub, w, a, 8'($urandom));
    end

    // Both requesters held for four transactions.
    single(1, 1, 8'h21, 8'hC3);
    da = 8'($urandom); db = 8'($urandom);
    req_a = 1; we_a = 1; addr_a = 8'h20; wdata_a = da;
    req_b = 1; we_b = 1; addr_b = 8'h21; wdata_b = db;
    cyc = 0; prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0; waited = 0;
      while (!got && waited < 6) begin
        tick(); cyc++; waited++;
        if (ack_a || ack_b) got = 1;
      end
      chk("tie_ack_seen", got, 1);
      if (got) begin
        wb = exp_winner_b(1'b1, 1'b1);
        chk("tie_order", {ack_a, ack_b}, {!wb, wb});
        chk("tie_spacing", cyc - prev, (k == 0) ? 2 : 3);
        prev = cyc;
        last_b_ref = wb;
        if (wb) ref_mem[8'h21] = db; else begin ref_mem[8'h20] = da; ref_valid[8'h20] = 1'b1; end
      end
      if (k == 3) begin req_a = 0; req_b = 0; end
    end
    tick();
    single(0, 0, 8'h20, 8'h00);
    single(1, 0, 8'h21, 8'h00);

    // Clear sweep with a request and a redundant clear_req arriving meanwhile.
    single(0, 1, 8'h00, 8'hFF);
    single(1, 1, 8'hFF, 8'hFF);
    cd0 = cd_count;
    clear_req = 1;
    tick();
    clear_req = 0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      chk("sweep_cycle", {mem_write, mem_read, mem_endereco, mem_dado, busy, clear_done, ack_a, ack_b},
          {1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
      if (i == 50) begin req_a = 1; we_a = 0; addr_a = 8'h00; end
      if (i == 100) clear_req = 1;
      if (i == 110) clear_req = 0;
      tick();
    end
    for (int i = 0; i < MEM_DEPTH; i++) begin ref_mem[i] = '0; ref_valid[i] = 1'b1; end
    chk("sweep_done", {clear_done, busy, mem_write, ack_a}, 4'b1000);
    tick();
    chk("post_sweep_access", {mem_read, mem_endereco, clear_done, ack_a}, {1'b1, 8'h00, 1'b0, 1'b0});
    tick();
    exp_rdata = ref_mem[0];
    last_b_ref = 1'b0;
    chk("post_sweep_ack", {ack_a, rdata}, {1'b1, exp_rdata});
    req_a = 0;
    tick(); tick(); tick();
    chk("clear_done_once", cd_count - cd0, 1);
    chk("no_second_sweep", busy, 0);
    single(1, 0, 8'hFF, 8'h00);

    // Reset in the middle of an access: write aborted, no ack.
    req_b = 1; we_b = 1; addr_b = 8'h33; wdata_b = 8'h99;
    tick();
    chk("abort_access_started", mem_write, 1);
    clr = 0; req_b = 0;
    #1;
    chk("abort_access_reset", {ack_a, ack_b, rdata, clear_done, busy, mem_read, mem_write,
                               mem_endereco, mem_dado}, 32'd0);
    last_b_ref = 1'b1; exp_rdata = '0;
    tick();
    clr = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_access_no_ack", {ack_a, ack_b, busy}, 3'b000);
    end
    single(0, 0, 8'h33, 8'h00);

    // Reset in the middle of a sweep: no clear_done, untouched words kept.
    single(0, 1, 8'h80, 8'h77);
    cd0 = cd_count;
    clear_req = 1;
    tick();
    clear_req = 0;
    for (int i = 0; i < 10; i++) tick();
    clr = 0;
    #1;
    chk("abort_sweep_reset", {busy, mem_write, clear_done}, 3'b000);
    last_b_ref = 1'b1;
    exp_rdata = '0;
    tick();
    clr = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_sweep_no_done", cd_count - cd0, 0);
    single(1, 0, 8'h80, 8'h00);

    // After reset the first tie goes to A again.
    last_b_ref = 1'b1;
    req_a = 1; we_a = 1; addr_a = 8'h50; wdata_a = 8'h11;
    req_b = 1; we_b = 1; addr_b = 8'h51; wdata_b = 8'h22;
    tick(); tick();
    wb = exp_winner_b(1'b1, 1'b1);
    chk("tie_after_reset", {ack_a, ack_b}, {!wb, wb});
    req_a = 0; req_b = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
